// File: rtl/mem_req_tracker_if.sv
// rtl/mem_req_tracker_if.sv - client request/response and controller issue/return bundle
interface mem_req_tracker_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_address;
   logic [DATA_W-1:0] req_data;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic [ADDR_W-1:0] rsp_address;
   logic [DATA_W-1:0] rsp_data;

   logic              rd_en;
   logic [ADDR_W-1:0] rd_address;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_address;
   logic [DATA_W-1:0] wr_data;

   logic              rd_ret_ack;
   logic [ADDR_W-1:0] rd_ret_address;
   logic [DATA_W-1:0] rd_ret_data;
   logic              wr_ret_ack;
   logic [ADDR_W-1:0] wr_ret_address;

   logic              err_unmatched;

   modport master (
      output req_valid, req_write, req_address, req_data, rsp_ready,
             rd_ret_ack, rd_ret_address, rd_ret_data, wr_ret_ack, wr_ret_address,
      input  req_ready, rsp_valid, rsp_write, rsp_address, rsp_data,
             rd_en, rd_address, wr_en, wr_address, wr_data, err_unmatched
   );

   modport slave (
      input  req_valid, req_write, req_address, req_data, rsp_ready,
             rd_ret_ack, rd_ret_address, rd_ret_data, wr_ret_ack, wr_ret_address,
      output req_ready, rsp_valid, rsp_write, rsp_address, rsp_data,
             rd_en, rd_address, wr_en, wr_address, wr_data, err_unmatched
   );
endinterface

// File: rtl/mem_req_tracker.sv
// rtl/mem_req_tracker.sv - in-order reorder buffer in front of the memory controller
// Tags are addresses; at most one live entry per address so returns match uniquely.
module mem_req_tracker #(
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int WR_ACK_EN = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_req_tracker_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0]  ent_vld;
   logic [DEPTH-1:0]  ent_done;
   logic [DEPTH-1:0]  ent_write;
   logic [ADDR_W-1:0] ent_addr [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              hazard;
   logic              rd_hit;
   logic              wr_hit;
   logic [PTR_W-1:0]  rd_idx;
   logic [PTR_W-1:0]  wr_idx;
   logic              req_ready_c;
   logic              rsp_valid_c;
   logic              accept;
   logic              pop;
   logic              wr_ack_live;

   logic              rd_en_q;
   logic [ADDR_W-1:0] rd_address_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_address_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              err_q;

   // Hazard covers done-but-unpopped entries too, keeping tags unique until pop.
   always_comb begin
      hazard = 1'b0;
      rd_hit = 1'b0;
      wr_hit = 1'b0;
      rd_idx = '0;
      wr_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && ent_addr[i] == bus.req_address)
            hazard = 1'b1;
         if (!rd_hit && ent_vld[i] && !ent_done[i] && !ent_write[i] &&
             ent_addr[i] == bus.rd_ret_address) begin
            rd_hit = 1'b1;
            rd_idx = PTR_W'(i);
         end
         if (!wr_hit && ent_vld[i] && !ent_done[i] && ent_write[i] &&
             ent_addr[i] == bus.wr_ret_address) begin
            wr_hit = 1'b1;
            wr_idx = PTR_W'(i);
         end
      end
   end

   assign req_ready_c = (count != FULL_CNT) && !hazard;
   assign rsp_valid_c = ent_vld[head] && ent_done[head];
   assign accept      = bus.req_valid && req_ready_c;
   assign pop         = rsp_valid_c && bus.rsp_ready;
   assign wr_ack_live = (WR_ACK_EN != 0) && bus.wr_ret_ack;

   assign bus.req_ready     = req_ready_c;
   assign bus.rsp_valid     = rsp_valid_c;
   assign bus.rsp_write     = ent_write[head];
   assign bus.rsp_address   = ent_addr[head];
   assign bus.rsp_data      = ent_write[head] ? '0 : ent_data[head];
   assign bus.rd_en         = rd_en_q;
   assign bus.rd_address    = rd_address_q;
   assign bus.wr_en         = wr_en_q;
   assign bus.wr_address    = wr_address_q;
   assign bus.wr_data       = wr_data_q;
   assign bus.err_unmatched = err_q;

   // Return, pop and accept never target the same slot, so their writes are independent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_vld      <= '0;
         ent_done     <= '0;
         ent_write    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] <= '0;
            ent_data[i] <= '0;
         end
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         rd_en_q      <= 1'b0;
         rd_address_q <= '0;
         wr_en_q      <= 1'b0;
         wr_address_q <= '0;
         wr_data_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         if (bus.rd_ret_ack) begin
            if (rd_hit) begin
               ent_done[rd_idx] <= 1'b1;
               ent_data[rd_idx] <= bus.rd_ret_data;
            end else begin
               err_q <= 1'b1;
            end
         end
         if (wr_ack_live) begin
            if (wr_hit)
               ent_done[wr_idx] <= 1'b1;
            else
               err_q <= 1'b1;
         end
         if (pop) begin
            ent_vld[head] <= 1'b0;
            head          <= head + PTR_W'(1);
         end
         if (accept) begin
            ent_vld[tail]   <= 1'b1;
            ent_done[tail]  <= bus.req_write && (WR_ACK_EN == 0);
            ent_write[tail] <= bus.req_write;
            ent_addr[tail]  <= bus.req_address;
            ent_data[tail]  <= bus.req_data;
            tail            <= tail + PTR_W'(1);
         end
         count <= count + CNT_W'(accept) - CNT_W'(pop);

         rd_en_q      <= accept && !bus.req_write;
         rd_address_q <= (accept && !bus.req_write) ? bus.req_address : '0;
         wr_en_q      <= accept && bus.req_write;
         wr_address_q <= (accept && bus.req_write) ? bus.req_address : '0;
         wr_data_q    <= (accept && bus.req_write) ? bus.req_data : '0;
      end
   end
endmodule
